bcd_seg_scan: RTL and testbench

- Consumes the 16-bit, 4-digit packed BCD result of the binary-to-BCD stage and drives one 4-digit multiplexed 7-segment group on the EGO1 board.
- Time-multiplexes the digits with a per-digit blanking gap to suppress ghosting.
- Applies leading-zero blanking and decimal-point insertion.
- Latches input only at frame boundaries, so a mid-frame BCD update never produces a torn display.

---
 rtl/bcd_seg_scan_if.sv | 27 ++
 rtl/bcd_seg_scan.sv | 119 +++++++++++
 tb/tb_bcd_seg_scan.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_scan_if.sv
// Bundles the BCD/decimal-point inputs and the multiplexed 7-segment outputs of bcd_seg_scan.
interface bcd_seg_scan_if;
  logic [15:0] bcd;
  logic [3:0]  dp_pos;
  logic        blank_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output bcd,
    output dp_pos,
    output blank_en,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  bcd,
    input  dp_pos,
    input  blank_en,
    output an,
    output seg,
    output frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// 4-digit multiplexed 7-segment scanner with per-slot blanking gap, leading-zero blanking,
// decimal points and frame-boundary input shadowing.
module bcd_seg_scan #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZB          = 1'b1
) (
  input logic          signal,
  input logic          rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam int unsigned   CntW     = $clog2(DIGIT_CYCLES);
  localparam logic [CntW-1:0] CntLast  = CntW'(DIGIT_CYCLES - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES - 1);

  typedef enum logic {StBlank, StShow} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       shadow_bcd_q, shadow_bcd_d;
  logic [3:0]        shadow_dp_q, shadow_dp_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              done_q, done_d;
  logic              frame_end;
  logic              blank_digit;
  logic [3:0]        nib;
  logic [6:0]        pat;

  always_ff @(posedge signal) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_bcd_q <= 16'h0000;
      shadow_dp_q  <= 4'b0000;
      an_q         <= 4'b0000;
      seg_q        <= 8'h00;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      done_q       <= done_d;
    end
  end

  // Slot sequencing: outputs registered this edge reflect the current counter position.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    cnt_d        = cnt_q + 1'b1;
    frame_end    = (cnt_q == CntLast) && (idx_q == 2'd3);
    if (cnt_q == CntLast) begin
      cnt_d   = '0;
      state_d = StBlank;
      idx_d   = idx_q + 2'd1;
    end else if (cnt_q == CntBlank) begin
      state_d = StShow;
    end
    if (frame_end) begin
      shadow_bcd_d = bus.bcd;
      shadow_dp_d  = bus.dp_pos;
    end
    done_d = frame_end;
  end

  // A digit is blanked when it and every more-significant digit are zero with no dp lit.
  always_comb begin
    blank_digit = 1'b0;
    if (LZB && bus.blank_en && (idx_q != 2'd0)) begin
      blank_digit = 1'b1;
      for (int j = 1; j < 4; j++) begin
        if ((2'(j) >= idx_q) && ((shadow_bcd_q[4*j +: 4] != 4'h0) || shadow_dp_q[j])) begin
          blank_digit = 1'b0;
        end
      end
    end
  end

  always_comb begin
    nib = shadow_bcd_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
  end

  always_comb begin
    an_d  = 4'b0000;
    seg_d = 8'h00;
    if ((state_q == StShow) && !blank_digit) begin
      an_d  = 4'b0001 << idx_q;
      seg_d = {shadow_dp_q[idx_q], pat};
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: directed vector table, hand sequences and randomized
// stimulus checked every cycle against a position-arithmetic reference model.
module tb_bcd_seg_scan;

  localparam int Dc = 8;
  localparam int Bc = 2;
  localparam int Fc = 4 * Dc;

  logic signal = 1'b0;
  logic rst_n;
  always #5 signal = ~signal;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(
    .DIGIT_CYCLES(Dc),
    .BLANK_CYCLES(Bc),
    .LZB         (1'b1)
  ) dut (
    .signal(signal),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: cyc counts unreset edges; position and digit follow by division.
  int          cyc = -1;
  int          m_pos, m_dig;
  bit          m_blk;
  logic [15:0] m_bcd = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  e_an = 4'h0;
  logic [7:0]  e_seg = 8'h0;
  logic        e_fd = 1'b0;
  logic [6:0]  lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                            7'h6F};

  function automatic logic [6:0] dec7(input logic [3:0] n);
    if (n > 4'd9) return 7'h40;
    return lut[n];
  endfunction

  always @(posedge signal) begin
    if (!rst_n) begin
      cyc = -1; m_bcd = 16'h0; m_dp = 4'h0;
      e_an = 4'h0; e_seg = 8'h0; e_fd = 1'b0;
    end else begin
      cyc   = cyc + 1;
      m_pos = cyc % Dc;
      m_dig = (cyc / Dc) % 4;
      m_blk = (m_dig > 0) && bus.blank_en && ((m_bcd >> (4 * m_dig)) == 16'h0) &&
              ((m_dp >> m_dig) == 4'h0);
      if (m_pos < Bc || m_blk) begin
        e_an = 4'h0; e_seg = 8'h0;
      end else begin
        e_an  = 4'(1 << m_dig);
        e_seg = {m_dp[m_dig], dec7(4'((m_bcd >> (4 * m_dig)) & 16'hF))};
      end
      e_fd = ((cyc % Fc) == Fc - 1);
      if (e_fd) begin
        m_bcd = bus.bcd;
        m_dp  = bus.dp_pos;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge signal);
    if (chk_en) begin
      check("model_an", {4'h0, bus.an}, {4'h0, e_an});
      check("model_seg", bus.seg, e_seg);
      check("model_frame_done", {7'h0, bus.frame_done}, {7'h0, e_fd});
    end
  endtask

  task automatic wait_pos(input int p);
    int g;
    g = 0;
    while ((cyc % Fc) != p && g < 3 * Fc) begin
      tick();
      g++;
    end
    if (g >= 3 * Fc) begin
      n_chk++; n_fail++;
      $display("FAIL wait_pos timeout got pos %0d expected %0d", cyc % Fc, p);
    end
  endtask

  task automatic wait_load();
    tick();
    wait_pos(Fc - 1);
  endtask

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic            be;
    logic [3:0]      lit;
    logic [3:0][7:0] seg;
  } vec_t;

  vec_t vecs [9];
  int   fd_cnt;

  initial begin
    vecs[0] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, 32'h00006D3F};
    vecs[1] = '{16'h0050, 4'b0000, 1'b0, 4'b1111, 32'h3F3F6D3F};
    vecs[2] = '{16'h0005, 4'b0010, 1'b1, 4'b0011, 32'h0000BF6D};
    vecs[3] = '{16'h00A0, 4'b0000, 1'b1, 4'b0011, 32'h0000403F};
    vecs[4] = '{16'h1234, 4'b0000, 1'b1, 4'b1111, 32'h065B4F66};
    vecs[5] = '{16'h9876, 4'b1000, 1'b1, 4'b1111, 32'hEF7F077D};
    vecs[6] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, 32'h0000003F};
    vecs[7] = '{16'h0F00, 4'b0000, 1'b1, 4'b0111, 32'h00403F3F};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, 32'h3F3F3F3F};

    rst_n = 1'b0;
    bus.bcd = 16'h1234; bus.dp_pos = 4'h0; bus.blank_en = 1'b1;
    @(posedge signal);
    chk_en = 1'b1;
    repeat (3) begin
      tick();
      check("reset_an", {4'h0, bus.an}, 8'h00);
      check("reset_seg", bus.seg, 8'h00);
    end
    rst_n = 1'b1;

    // First frame after reset shows only "0" in cycles 2..7.
    fd_cnt = 0;
    for (int k = 0; k < Fc; k++) begin
      tick();
      check("first_an", {4'h0, bus.an}, (k >= 2 && k <= 7) ? 8'h01 : 8'h00);
      check("first_seg", bus.seg, (k >= 2 && k <= 7) ? 8'h3F : 8'h00);
      if (bus.frame_done) fd_cnt++;
    end
    check("first_frame_done_at_31", {7'h0, bus.frame_done}, 8'h01);
    check("first_frame_done_count", 8'(fd_cnt), 8'd1);

    for (int v = 0; v < 9; v++) begin
      bus.bcd = vecs[v].bcd; bus.dp_pos = vecs[v].dp; bus.blank_en = vecs[v].be;
      wait_load();
      for (int d = 0; d < 4; d++) begin
        wait_pos(Dc * d + 4);
        check($sformatf("vec%0d_an%0d", v, d), {4'h0, bus.an},
              vecs[v].lit[d] ? 8'(1 << d) : 8'h00);
        check($sformatf("vec%0d_seg%0d", v, d), bus.seg, vecs[v].seg[d]);
      end
    end

    // Mid-frame input change must not tear the current frame.
    bus.bcd = 16'h1111; bus.dp_pos = 4'h0; bus.blank_en = 1'b1;
    wait_load();
    wait_pos(Dc + 3);
    bus.bcd = 16'h9999;
    fd_cnt = 0;
    for (int k = 0; k < Fc; k++) begin
      tick();
      if (bus.frame_done) fd_cnt++;
      if ((cyc % Fc) == 2 * Dc + 4) check("tear_d2", bus.seg, 8'h06);
      if ((cyc % Fc) == 3 * Dc + 4) check("tear_d3", bus.seg, 8'h06);
      if ((cyc % Fc) == 4) check("tear_next_d0", bus.seg, 8'h6F);
    end
    check("tear_frame_done_count", 8'(fd_cnt), 8'd1);

    // Reset during digit 2 show.
    wait_pos(2 * Dc + 4);
    rst_n = 1'b0;
    tick();
    check("midrst_an", {4'h0, bus.an}, 8'h00);
    check("midrst_seg", bus.seg, 8'h00);
    check("midrst_fd", {7'h0, bus.frame_done}, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("midrst_restart_an", {4'h0, bus.an}, 8'h01);
    check("midrst_restart_seg", bus.seg, 8'h3F);

    // Randomized stimulus, checked every cycle by the model inside tick().
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        logic [15:0] b;
        b = 16'($urandom);
        for (int n = 0; n < 4; n++) if ($urandom_range(0, 1) == 0) b[4*n +: 4] = 4'h0;
        bus.bcd = b;
        bus.dp_pos = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(0, 63) == 0) bus.blank_en = ~bus.blank_en;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
